envelope_sample_shaper: RTL and testbench

//  Consumes the attack stage's shift_amount/done and owns the note-level envelope FSM (IDLE/ATTACK/SUSTAIN/RELEASE).

---
 rtl/synth_env_pkg.sv | 35 +++
 rtl/release_step_ticker.sv | 33 +++
 rtl/envelope_sample_shaper.sv | 164 ++++++++++++++++
 tb/tb_envelope_sample_shaper.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_env_pkg.sv
// ---------------------------------------------------------------------------
// synth_env_pkg
// Shared definitions for the synth envelope blocks.
//   env_state_t          note-level envelope states (encoding visible on the
//                        env_state port: 0=IDLE 1=ATTACK 2=SUSTAIN 3=RELEASE)
//   SHIFT_MAX            largest shift, i.e. quietest audible setting
//   RELEASE_UNIT_DEFAULT clock cycles per release step at release_value=0
//   CNT_W                release step counter width (covers 16*RELEASE_UNIT)
//   BLANK_CYCLES         ATTACK cycles in which attack_done/attack_shift are
//                        not trusted (restart pulse cycle plus two more)
//   release_period()     step period in cycles for a given release_value
// ---------------------------------------------------------------------------
package synth_env_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_t;

  localparam logic [3:0] SHIFT_MAX            = 4'd15;
  localparam int         RELEASE_UNIT_DEFAULT = 500000;
  localparam int         CNT_W                = 36;

  // The attack stage sees our restart pulse one edge late, so its done and
  // shift outputs are stale during the pulse cycle and the two that follow.
  localparam logic [1:0] BLANK_CYCLES         = 2'd3;

  function automatic logic [CNT_W-1:0] release_period(input logic [3:0] release_value,
                                                      input int         unit);
    return (CNT_W'(release_value) + CNT_W'(1)) * CNT_W'(unit);
  endfunction

endpackage

// File: rtl/release_step_ticker.sv
// ---------------------------------------------------------------------------
// release_step_ticker
// Loadable down-counter that emits a one-cycle tick every 'period' cycles.
//   clock   in   system clock, posedge
//   reset   in   synchronous restart: reloads the counter from period
//   period  in   step period in cycles (must be >= 1); sampled on every reload
//   tick    out  high for one cycle at terminal count
// ---------------------------------------------------------------------------
module release_step_ticker
  import synth_env_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);

  logic [CNT_W-1:0] count;

  assign tick = (count == '0);

  // Loading period-1 makes the first tick land exactly 'period' cycles after
  // the restart. Reloading at terminal count picks up the period presented
  // in that cycle, so a rate change only affects the following step.
  always_ff @(posedge clock) begin
    if (reset || tick) begin
      count <= period - CNT_W'(1);
    end else begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/envelope_sample_shaper.sv
// ---------------------------------------------------------------------------
// envelope_sample_shaper
// Note-level envelope FSM (IDLE/ATTACK/SUSTAIN/RELEASE) that scales signed
// audio samples by an arithmetic right shift. Restarts the attack stage with
// a one-cycle pulse when a note starts.
//   clock            in   system clock, posedge
//   reset            in   synchronous, active-high
//   note_on          in   gate level, high while the key is held
//   attack_shift     in   shift_amount from the attack stage
//   attack_done      in   done from the attack stage
//   release_value    in   release rate select, step = (value+1)*RELEASE_UNIT
//   sample_in        in   signed input sample
//   sample_in_valid  in   sample_in qualifier
//   attack_restart   out  one-cycle pulse, drives the attack stage reset
//   sample_out       out  shaped signed sample, one cycle latency
//   sample_out_valid out  sample_out qualifier
//   env_state        out  current envelope state
//   cur_shift        out  shift applied to the sample in this cycle
// ---------------------------------------------------------------------------
module envelope_sample_shaper
  import synth_env_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int RELEASE_UNIT = RELEASE_UNIT_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       note_on,
  input  logic [3:0]                 attack_shift,
  input  logic                       attack_done,
  input  logic [3:0]                 release_value,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_in_valid,
  output logic                       attack_restart,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_out_valid,
  output logic [1:0]                 env_state,
  output logic [3:0]                 cur_shift
);

  env_state_t                 state_q;
  env_state_t                 state_d;
  logic [3:0]                 rel_shift_q;
  logic [3:0]                 rel_shift_d;
  logic [1:0]                 blank_q;
  logic [1:0]                 blank_d;
  logic                       restart_d;
  logic                       release_load;
  logic                       step_tick;
  logic [CNT_W-1:0]           step_period;
  logic signed [SAMPLE_W-1:0] shifted;

  assign step_period = release_period(release_value, RELEASE_UNIT);

  // The step counter restarts on every entry into RELEASE so the first step
  // comes a full period after the key is released.
  release_step_ticker u_ticker (
    .clock  (clock),
    .reset  (reset | release_load),
    .period (step_period),
    .tick   (step_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ENV_IDLE;
      rel_shift_q    <= SHIFT_MAX;
      blank_q        <= '0;
      attack_restart <= 1'b0;
    end else begin
      state_q        <= state_d;
      rel_shift_q    <= rel_shift_d;
      blank_q        <= blank_d;
      attack_restart <= restart_d;
    end
  end

  // Next-state logic. The restart pulse is registered, so it is high during
  // the first ATTACK cycle. ATTACK can only be entered from IDLE or RELEASE,
  // which guarantees the pulse is never high two cycles in a row.
  always_comb begin
    state_d      = state_q;
    rel_shift_d  = rel_shift_q;
    blank_d      = blank_q;
    restart_d    = 1'b0;
    release_load = 1'b0;
    cur_shift    = SHIFT_MAX;

    case (state_q)
      ENV_IDLE: begin
        cur_shift = SHIFT_MAX;
        if (note_on) begin
          state_d   = ENV_ATTACK;
          restart_d = 1'b1;
          blank_d   = BLANK_CYCLES;
        end
      end

      ENV_ATTACK: begin
        cur_shift = attack_shift;
        if (blank_q != 2'd0) begin
          blank_d = blank_q - 2'd1;
        end
        // Releasing the key wins over a simultaneous attack completion.
        if (!note_on) begin
          state_d      = ENV_RELEASE;
          rel_shift_d  = attack_shift;
          release_load = 1'b1;
        end else if ((blank_q == 2'd0) && (attack_done || (attack_shift == 4'd0))) begin
          state_d = ENV_SUSTAIN;
        end
      end

      ENV_SUSTAIN: begin
        cur_shift = 4'd0;
        if (!note_on) begin
          state_d      = ENV_RELEASE;
          rel_shift_d  = 4'd0;
          release_load = 1'b1;
        end
      end

      ENV_RELEASE: begin
        cur_shift = rel_shift_q;
        // A new key press wins over a release step in the same cycle.
        if (note_on) begin
          state_d   = ENV_ATTACK;
          restart_d = 1'b1;
          blank_d   = BLANK_CYCLES;
        end else if (step_tick) begin
          if (rel_shift_q == SHIFT_MAX) begin
            state_d = ENV_IDLE;
          end else begin
            rel_shift_d = rel_shift_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ENV_IDLE;
      end
    endcase
  end

  assign env_state = state_q;

  // Uses the shift of the current (pre-transition) state.
  assign shifted = sample_in >>> cur_shift;

  // Output register holds its last value while no new sample arrives; IDLE
  // mutes the sample but still forwards the valid strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      sample_out_valid <= sample_in_valid;
      if (sample_in_valid) begin
        sample_out <= (state_q == ENV_IDLE) ? '0 : shifted;
      end
    end
  end

endmodule

// File: tb/tb_envelope_sample_shaper.sv
// ---------------------------------------------------------------------------
// tb_envelope_sample_shaper
// Self-checking bench for envelope_sample_shaper with RELEASE_UNIT=4.
// A behavioural envelope model runs alongside the DUT and every output is
// compared after each clock edge; directed scenarios add explicit checks.
// ---------------------------------------------------------------------------
module tb_envelope_sample_shaper;

  localparam int UNIT = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               note_on;
  logic [3:0]         attack_shift;
  logic               attack_done;
  logic [3:0]         release_value;
  logic signed [15:0] sample_in;
  logic               sample_in_valid;
  logic               attack_restart;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic [1:0]         env_state;
  logic [3:0]         cur_shift;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0..3, cycles spent in attack, release progress.
  int mPhase   = 0;
  int mAge     = 0;
  int mRel     = 15;
  int mElapsed = 0;
  int mTarget  = UNIT;
  int mRestart = 0;
  int mOut     = 0;
  int mVout    = 0;

  envelope_sample_shaper #(.SAMPLE_W(16), .RELEASE_UNIT(UNIT)) dut (
    .clock            (clock),
    .reset            (reset),
    .note_on          (note_on),
    .attack_shift     (attack_shift),
    .attack_done      (attack_done),
    .release_value    (release_value),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .attack_restart   (attack_restart),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .env_state        (env_state),
    .cur_shift        (cur_shift)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Division by 2^s rounded toward minus infinity.
  function automatic int floorShift(input int v, input int s);
    int d;
    d = 1 << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int modelShift(input int aShift);
    case (mPhase)
      0:       return 15;
      1:       return aShift;
      2:       return 0;
      default: return mRel;
    endcase
  endfunction

  // One clock cycle: drive inputs, advance the model at the edge, compare.
  task automatic applyStimulus(input bit rst, input bit note, input int aShift, input bit done,
                               input int rv, input int sin, input bit vin);
    int cur;
    reset           = rst;
    note_on         = note;
    attack_shift    = 4'(aShift);
    attack_done     = done;
    release_value   = 4'(rv);
    sample_in       = 16'(sin);
    sample_in_valid = vin;
    @(posedge clock);
    if (rst) begin
      mPhase = 0; mAge = 0; mRel = 15; mElapsed = 0;
      mRestart = 0; mOut = 0; mVout = 0;
    end else begin
      cur   = modelShift(aShift);
      mVout = vin;
      if (vin) mOut = (mPhase == 0) ? 0 : floorShift(sin, cur);
      mRestart = 0;
      case (mPhase)
        0: if (note) begin mPhase = 1; mRestart = 1; mAge = 0; end
        1: begin
          if (!note) begin
            mPhase = 3; mRel = aShift; mElapsed = 0; mTarget = (rv + 1) * UNIT;
          end else if (mAge >= 3 && (done || aShift == 0)) begin
            mPhase = 2;
          end
          mAge++;
        end
        2: if (!note) begin
          mPhase = 3; mRel = 0; mElapsed = 0; mTarget = (rv + 1) * UNIT;
        end
        default: begin
          if (note) begin
            mPhase = 1; mRestart = 1; mAge = 0;
          end else if (mElapsed == mTarget - 1) begin
            if (mRel == 15) mPhase = 0;
            else mRel++;
            mElapsed = 0;
            mTarget  = (rv + 1) * UNIT;
          end else begin
            mElapsed++;
          end
        end
      endcase
    end
    #1;
    checkOutput("env_state", env_state, mPhase);
    checkOutput("cur_shift", cur_shift, modelShift(aShift));
    checkOutput("attack_restart", attack_restart, mRestart);
    checkOutput("sample_out_valid", sample_out_valid, mVout);
    checkOutput("sample_out", sample_out, mOut);
  endtask

  initial begin
    int relCycles;
    bit note;
    int rv;

    // Reset and idle muting
    applyStimulus(1, 0, 0, 0, 1, 1000, 1);
    checkOutput("reset_state", env_state, 0);
    checkOutput("reset_shift", cur_shift, 15);
    checkOutput("reset_out", sample_out, 0);
    checkOutput("reset_valid", sample_out_valid, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 1, 1000, 1);
    checkOutput("idle_mute", sample_out, 0);
    checkOutput("idle_valid", sample_out_valid, 1);

    // Note on: restart pulse, then shifted sample
    applyStimulus(0, 1, 3, 0, 1, 800, 1);
    checkOutput("restart_pulse", attack_restart, 1);
    checkOutput("attack_entry", env_state, 1);
    applyStimulus(0, 1, 3, 0, 1, 800, 1);
    checkOutput("attack_scaled", sample_out, 100);
    checkOutput("restart_single", attack_restart, 0);

    // Blanking then sustain
    applyStimulus(0, 1, 3, 1, 1, 800, 1);
    checkOutput("blank_1", env_state, 1);
    applyStimulus(0, 1, 3, 1, 1, 800, 1);
    checkOutput("blank_2", env_state, 1);
    applyStimulus(0, 1, 3, 1, 1, -800, 1);
    checkOutput("sustain_entry", env_state, 2);
    applyStimulus(0, 1, 3, 0, 1, -800, 1);
    checkOutput("sustain_full", sample_out, -800);

    // Full release at release_value=1: 16 steps of 8 cycles
    relCycles = 0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 3, 0, 1, 1234, 1);
      if (env_state == 2'd3) relCycles++;
      else if (relCycles > 0) break;
    end
    checkOutput("release_cycles", relCycles, 128);
    checkOutput("release_end_idle", env_state, 0);
    applyStimulus(0, 0, 3, 0, 1, 1234, 1);
    checkOutput("release_end_mute", sample_out, 0);

    // Release from attack at shift 9, re-trigger mid release
    applyStimulus(0, 1, 9, 0, 1, 500, 1);
    repeat (2) applyStimulus(0, 1, 9, 0, 1, 500, 1);
    applyStimulus(0, 0, 9, 0, 1, 500, 1);
    checkOutput("release_from_attack", cur_shift, 9);
    repeat (3) applyStimulus(0, 0, 9, 0, 1, 500, 1);
    applyStimulus(0, 1, 15, 0, 1, 500, 1);
    checkOutput("retrigger_pulse", attack_restart, 1);
    checkOutput("retrigger_state", env_state, 1);

    // Most negative sample at shift 15, then reset while releasing
    applyStimulus(0, 1, 15, 0, 1, -32768, 1);
    applyStimulus(0, 1, 15, 0, 1, -32768, 1);
    checkOutput("neg_full_shift", sample_out, -1);
    applyStimulus(0, 0, 15, 0, 1, 700, 1);
    checkOutput("pre_reset_release", env_state, 3);
    applyStimulus(1, 0, 15, 0, 1, 700, 1);
    checkOutput("abort_state", env_state, 0);
    checkOutput("abort_out", sample_out, 0);
    checkOutput("abort_valid", sample_out_valid, 0);
    checkOutput("abort_no_pulse", attack_restart, 0);

    // Randomized traffic against the model
    note = 1'b0;
    rv   = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) note = !note;
      if ($urandom_range(0, 29) == 0) rv = int'($urandom_range(0, 2));
      applyStimulus($urandom_range(0, 299) == 0, note, int'($urandom_range(0, 15)),
                    $urandom_range(0, 3) == 0, rv, int'($urandom_range(0, 65535)) - 32768,
                    $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
